kul_mul16_seq: RTL and testbench

- Sequential 16x16 approximate multiplier controller built around one shared, externally instantiated 8x8 recursive approximate sub-multiplier.
- Splits each 16-bit operand pair into four 8x8 partial products, issued one per cycle in order LL, HL, LH, HH.
- Accumulates the shifted sub-products and returns a 32-bit result over valid/ready handshakes.
- Trades about 4x throughput for one 8x8 instance instead of four; it sits between the operand source and the result consumer.

---
 rtl/kul_mul16_seq.sv | 130 +++++++++++++
 tb/tb_kul_mul16_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kul_mul16_seq.sv
// Sequential 16x16 approximate multiplier: four 8x8 partial products (LL, HL, LH, HH)
// issued one per cycle to a shared external sub-multiplier, accumulated into 32 bits.
module kul_mul16_seq #(
   parameter int SUB_LAT = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic             sub_valid,
   output logic [7:0]       sub_a,
   output logic [7:0]       sub_b,
   input  logic [15:0]      sub_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_y,
   output logic             busy,
   output logic [CNT_W-1:0] op_cnt
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [1:0] S_AFTER_ISSUE = (SUB_LAT > 0) ? S_DRAIN : S_DONE;

   logic [1:0]  state;
   logic [1:0]  idx;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [31:0] acc;
   logic [1:0]  issue_sh;
   logic        ret_v;
   logic [1:0]  ret_sh;
   logic [31:0] ret_term;

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign sub_valid = (state == S_ISSUE);
   assign out_valid = (state == S_DONE);
   assign out_y     = acc;

   // Shift code per issue: 0 -> <<0, 1 -> <<8, 2 -> <<16.
   assign issue_sh = {idx[1] & idx[0], idx[1] ^ idx[0]};
   assign ret_term = {16'h0000, sub_y} << {ret_sh, 3'b000};

   generate
      if (SUB_LAT == 0) begin : g_comb
         assign ret_v  = sub_valid;
         assign ret_sh = issue_sh;
      end else begin : g_pipe
         logic [SUB_LAT-1:0] tag_v;
         logic [1:0]         tag_sh [SUB_LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               tag_v <= '0;
               for (int i = 0; i < SUB_LAT; i++) tag_sh[i] <= 2'd0;
            end else begin
               tag_v[0]  <= sub_valid;
               tag_sh[0] <= issue_sh;
               for (int i = 1; i < SUB_LAT; i++) begin
                  tag_v[i]  <= tag_v[i-1];
                  tag_sh[i] <= tag_sh[i-1];
               end
            end
         end

         assign ret_v  = tag_v[SUB_LAT-1];
         assign ret_sh = tag_sh[SUB_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx    <= 2'd0;
         a_q    <= 16'h0000;
         b_q    <= 16'h0000;
         sub_a  <= 8'h00;
         sub_b  <= 8'h00;
         acc    <= 32'h0000_0000;
         op_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= in_b;
                  acc   <= 32'h0000_0000;
                  idx   <= 2'd0;
                  sub_a <= in_a[7:0];
                  sub_b <= in_b[7:0];
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (ret_v) acc <= acc + ret_term;
               idx <= idx + 2'd1;
               // Operands registered one cycle ahead so they line up with sub_valid.
               case (idx)
                  2'd0: begin sub_a <= a_q[15:8]; sub_b <= b_q[7:0];  end
                  2'd1: begin sub_a <= a_q[7:0];  sub_b <= b_q[15:8]; end
                  2'd2: begin sub_a <= a_q[15:8]; sub_b <= b_q[15:8]; end
                  default: ;
               endcase
               if (idx == 2'd3) state <= S_AFTER_ISSUE;
            end
            S_DRAIN: begin
               if (ret_v) begin
                  acc <= acc + ret_term;
                  if (ret_sh == 2'd2) state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  op_cnt <= op_cnt + CNT_W'(1);
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kul_mul16_seq.sv
// Bench for kul_mul16_seq: a combinational (exact or approximate) stub on a SUB_LAT=0
// instance and a two-cycle exact stub on a SUB_LAT=2, CNT_W=2 instance.
module tb_kul_mul16_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   // SUB_LAT=0 instance
   logic        rst_n0, in_valid0, in_ready0, sub_valid0, out_valid0, out_ready0, busy0;
   logic [15:0] in_a0, in_b0, sub_y0, op_cnt0;
   logic [7:0]  sub_a0, sub_b0;
   logic [31:0] out_y0;
   logic        approx_mode;

   // SUB_LAT=2, CNT_W=2 instance
   logic        rst_n1, in_valid1, in_ready1, sub_valid1, out_valid1, out_ready1, busy1;
   logic [15:0] in_a1, in_b1, sub_y1, d1, d2;
   logic [1:0]  op_cnt1;
   logic [7:0]  sub_a1, sub_b1;
   logic [31:0] out_y1;

   kul_mul16_seq #(.SUB_LAT(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_a(in_a0), .in_b(in_b0), .sub_valid(sub_valid0), .sub_a(sub_a0), .sub_b(sub_b0),
      .sub_y(sub_y0), .out_valid(out_valid0), .out_ready(out_ready0), .out_y(out_y0),
      .busy(busy0), .op_cnt(op_cnt0)
   );

   kul_mul16_seq #(.SUB_LAT(2), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .sub_valid(sub_valid1), .sub_a(sub_a1), .sub_b(sub_b1),
      .sub_y(sub_y1), .out_valid(out_valid1), .out_ready(out_ready1), .out_y(out_y1),
      .busy(busy1), .op_cnt(op_cnt1)
   );

   // Recursive approximate multiplier: 2x2 block returns 7 for 3*3.
   function automatic logic [3:0] kul2(input logic [1:0] a, input logic [1:0] b);
      logic [3:0] wa, wb;
      wa = {2'b00, a};
      wb = {2'b00, b};
      return (a == 2'd3 && b == 2'd3) ? 4'd7 : wa * wb;
   endfunction

   function automatic logic [7:0] kul4(input logic [3:0] a, input logic [3:0] b);
      return {4'h0, kul2(a[1:0], b[1:0])} + ({4'h0, kul2(a[3:2], b[1:0])} << 2) +
             ({4'h0, kul2(a[1:0], b[3:2])} << 2) + ({4'h0, kul2(a[3:2], b[3:2])} << 4);
   endfunction

   function automatic logic [15:0] kul8(input logic [7:0] a, input logic [7:0] b);
      return {8'h00, kul4(a[3:0], b[3:0])} + ({8'h00, kul4(a[7:4], b[3:0])} << 4) +
             ({8'h00, kul4(a[3:0], b[7:4])} << 4) + ({8'h00, kul4(a[7:4], b[7:4])} << 8);
   endfunction

   always_comb begin
      sub_y0 = 16'h0000;
      if (approx_mode) sub_y0 = kul8(sub_a0, sub_b0);
      else             sub_y0 = {8'h00, sub_a0} * {8'h00, sub_b0};
   end

   always @(posedge clk) begin
      d1 <= {8'h00, sub_a1} * {8'h00, sub_b1};
      d2 <= d1;
   end
   assign sub_y1 = d2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: compare on every output handshake.
   always @(negedge clk) begin
      if (rst_n0 && out_valid0 && out_ready0) begin
         if (exp_q0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut0 out_y: got 0x%08h with nothing expected", out_y0);
         end else check("dut0 out_y", out_y0, exp_q0.pop_front());
      end
      if (rst_n1 && out_valid1 && out_ready1) begin
         if (exp_q1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut1 out_y: got 0x%08h with nothing expected", out_y1);
         end else check("dut1 out_y", out_y1, exp_q1.pop_front());
      end
   end

   task automatic wait_ready0();
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready0 && t < 50) begin @(negedge clk); t++; end
      check("dut0 in_ready wait", in_ready0, 1);
   endtask

   task automatic wait_ready1();
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready1 && t < 50) begin @(negedge clk); t++; end
      check("dut1 in_ready wait", in_ready1, 1);
   endtask

   task automatic run_op0(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
      int lat;
      logic [1:0] idx;
      logic [7:0] ea, eb;
      wait_ready0();
      in_valid0 = 1'b1; in_a0 = a; in_b0 = b;
      exp_q0.push_back(exp);
      @(posedge clk); #1 in_valid0 = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk); lat++;
         if (lat <= 4) begin
            idx = 2'(lat - 1);
            ea = idx[0] ? a[15:8] : a[7:0];
            eb = idx[1] ? b[15:8] : b[7:0];
            check("dut0 sub_valid", sub_valid0, 1);
            check("dut0 sub_ab", {16'h0000, sub_a0, sub_b0}, {16'h0000, ea, eb});
         end
         if (out_valid0) break;
      end
      check("dut0 latency", lat, 5);
      check("dut0 sub_valid low", sub_valid0, 0);
   endtask

   task automatic run_op1(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
      int lat;
      wait_ready1();
      in_valid1 = 1'b1; in_a1 = a; in_b1 = b;
      exp_q1.push_back(exp);
      @(posedge clk); #1 in_valid1 = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk); lat++;
         if (lat <= 4) check("dut1 sub_valid", sub_valid1, 1);
         if (out_valid1) break;
      end
      check("dut1 latency", lat, 7);
   endtask

   logic [15:0] t1_a [5];
   logic [15:0] t1_b [5];
   logic [31:0] t1_y [5];
   logic [1:0]  t1_c [5];

   initial begin
      t1_a = '{16'h1234, 16'hFFFF, 16'h0001, 16'h00FF, 16'h0002};
      t1_b = '{16'h5678, 16'hFFFF, 16'h0001, 16'h0100, 16'h0003};
      t1_y = '{32'h0626_0060, 32'hFFFE_0001, 32'h0000_0001, 32'h0000_FF00, 32'h0000_0006};
      t1_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      rst_n0 = 1'b0; rst_n1 = 1'b0; approx_mode = 1'b0;
      in_valid0 = 1'b0; in_a0 = 16'h0; in_b0 = 16'h0; out_ready0 = 1'b1;
      in_valid1 = 1'b0; in_a1 = 16'h0; in_b1 = 16'h0; out_ready1 = 1'b1;
      #1;
      check("rst in_ready", in_ready0, 1);
      check("rst sub_valid", sub_valid0, 0);
      check("rst sub_ab", {sub_a0, sub_b0}, 0);
      check("rst out_valid", out_valid0, 0);
      check("rst out_y", out_y0, 0);
      check("rst busy", busy0, 0);
      check("rst op_cnt", op_cnt0, 0);
      repeat (2) @(negedge clk);
      rst_n0 = 1'b1; rst_n1 = 1'b1;

      approx_mode = 1'b1;
      run_op0(16'h0003, 16'h0003, 32'h0000_0007);
      wait_ready0();
      check("dut0 op_cnt approx", op_cnt0, 1);
      approx_mode = 1'b0;

      run_op0(16'hFFFF, 16'h0001, 32'h0000_FFFF);
      run_op0(16'h0100, 16'h0100, 32'h0001_0000);
      run_op0(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
      wait_ready0();
      check("dut0 op_cnt exact", op_cnt0, 4);

      // Backpressure: result held, in_valid pulses ignored.
      out_ready0 = 1'b0;
      run_op0(16'h0012, 16'h0034, 32'h0000_03A8);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 in_valid0 = i[0]; in_a0 = 16'hFFFF; in_b0 = 16'hFFFF;
         @(negedge clk);
         check("bp out_valid", out_valid0, 1);
         check("bp out_y", out_y0, 32'h0000_03A8);
         check("bp in_ready", in_ready0, 0);
      end
      @(posedge clk); #1 in_valid0 = 1'b0; out_ready0 = 1'b1;
      @(negedge clk);
      check("bp in_ready before hs", in_ready0, 0);
      @(negedge clk);
      check("bp in_ready after hs", in_ready0, 1);
      check("bp out_valid after hs", out_valid0, 0);
      check("bp op_cnt", op_cnt0, 5);

      // Reset in the middle of ISSUE idx2.
      wait_ready0();
      in_valid0 = 1'b1; in_a0 = 16'hABCD; in_b0 = 16'h1234;
      @(posedge clk); #1 in_valid0 = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-rst sub_ab idx2", {sub_a0, sub_b0}, 16'hCD12);
      #2 rst_n0 = 1'b0;
      #1;
      check("mid rst in_ready", in_ready0, 1);
      check("mid rst sub_valid", sub_valid0, 0);
      check("mid rst sub_ab", {sub_a0, sub_b0}, 0);
      check("mid rst out_valid", out_valid0, 0);
      check("mid rst out_y", out_y0, 0);
      check("mid rst busy", busy0, 0);
      check("mid rst op_cnt", op_cnt0, 0);
      @(negedge clk); rst_n0 = 1'b1;
      run_op0(16'h0002, 16'h0003, 32'h0000_0006);
      wait_ready0();
      check("post rst op_cnt", op_cnt0, 1);

      // Delayed sub-multiplier and 2-bit counter wrap.
      for (int k = 0; k < 5; k++) begin
         run_op1(t1_a[k], t1_b[k], t1_y[k]);
         wait_ready1();
         check("dut1 op_cnt", op_cnt1, t1_c[k]);
      end

      repeat (3) @(negedge clk);
      check("dut0 queue empty", exp_q0.size(), 0);
      check("dut1 queue empty", exp_q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout: bench did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

endmodule
